module_ctrl_despliegue: RTL

- Sequencing controller for the two-digit 7-segment display path of the 4-bit multiplier.
- Decides which value owns the display: operand A, operand B or the product. Drives the one-hot select lines of the display source mux (load_a/load_b/load_m).
- Time-multiplexes the two common anodes (units/tens) at a fixed refresh rate.
- Sits between the operand-capture/multiplier logic and the display datapath (mux → bin-to-BCD → digit registers → segment decoder).

---
 rtl/module_ctrl_despliegue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/module_ctrl_despliegue.sv
// Display sequencing for the 2-digit multiplier readout: one-hot source select (A/B/product) plus anode multiplexing.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module module_ctrl_despliegue #(
  parameter int REFRESH_DIV = 27000,
  parameter int HOLD_CYCLES = 54000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic       m_valid,
  input  logic       dec_is_zero,
  output logic       load_a,
  output logic       load_b,
  output logic       load_m,
  output logic       dig_sel,
  output logic [1:0] anodo
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_M} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic            m_seen_q, m_seen_d;
  logic            dig_sel_q, dig_sel_d;
  logic            load_a_q, load_a_d;
  logic            load_b_q, load_b_d;
  logic            load_m_q, load_m_d;
  logic [1:0]      anodo_q, anodo_d;
  logic            blank_tens;

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_tens = dec_is_zero;
`else
  logic unused_dec_is_zero;
  assign unused_dec_is_zero = dec_is_zero;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    m_seen_d = m_seen_q;
    if (m_valid) begin
      state_d  = S_M;
      m_seen_d = 1'b1;
      hold_d   = '0;
    end else if (b_valid) begin
      state_d = S_B;
      hold_d  = '0;
    end else if (a_valid) begin
      state_d = S_A;
      hold_d  = '0;
    end else if (state_q == S_A || state_q == S_B) begin
      // Without a product yet, the operand stays up and the counter saturates.
      if (hold_q == HOLD_LAST) begin
        if (m_seen_q) begin
          state_d = S_M;
          hold_d  = '0;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    // Refresh phase is independent of which source is shown.
    if (ref_q == REF_LAST) begin
      ref_d     = '0;
      dig_sel_d = ~dig_sel_q;
    end else begin
      ref_d     = ref_q + 1'b1;
      dig_sel_d = dig_sel_q;
    end

    load_a_d = (state_d == S_A);
    load_b_d = (state_d == S_B);
    load_m_d = (state_d == S_M);

    if (state_d == S_IDLE)    anodo_d = 2'b11;
    else if (!dig_sel_d)      anodo_d = 2'b10;
    else if (blank_tens)      anodo_d = 2'b11;
    else                      anodo_d = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      ref_q     <= '0;
      m_seen_q  <= 1'b0;
      dig_sel_q <= 1'b0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      load_m_q  <= 1'b0;
      anodo_q   <= 2'b11;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ref_q     <= ref_d;
      m_seen_q  <= m_seen_d;
      dig_sel_q <= dig_sel_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      load_m_q  <= load_m_d;
      anodo_q   <= anodo_d;
    end
  end

  assign load_a  = load_a_q;
  assign load_b  = load_b_q;
  assign load_m  = load_m_q;
  assign dig_sel = dig_sel_q;
  assign anodo   = anodo_q;

endmodule
